// File: rtl/mf_pkg.sv
// Shared definitions for the receive matched filter: widths, FSM states,
// coefficient table, output saturation and the optional slicer (MF_SLICER_EN).
package mf_pkg;

  localparam int unsigned SAMP_W = 18;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned NTAPS  = 31;
  localparam int unsigned NHALF  = 16;
  localparam int unsigned NSETS  = 8;
  localparam int unsigned PROD_W = 2 * SAMP_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } mf_state_e;

  typedef logic signed [SAMP_W-1:0] coeff_tbl_t [NSETS][NHALF];

  // Only set 0 carries the pulse shape; the centre tap is b[15].
  localparam coeff_tbl_t COEFF_TBL = '{
    0: '{11: -18'sd6305, 12: 18'sd23347, 13: 18'sd61031,
         14: 18'sd92574, 15: 18'sd104858, default: '0},
    default: '{default: '0}
  };

  localparam logic signed [SAMP_W-1:0] Y_MAX = 18'sd131071;
  localparam logic signed [SAMP_W-1:0] Y_MIN = 18'sh20000;
  localparam logic signed [ACC_W-1:0]  ACC_YMAX = 40'sd131071;
  localparam logic signed [ACC_W-1:0]  ACC_YMIN = -40'sd131072;

  localparam logic signed [SAMP_W-1:0] SLICE_LO  = -18'sd65536;
  localparam logic signed [SAMP_W-1:0] SLICE_MID = 18'sd0;
  localparam logic signed [SAMP_W-1:0] SLICE_HI  = 18'sd65536;

  function automatic logic signed [SAMP_W-1:0] sat_y(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> 16;
    if (sh > ACC_YMAX)      return Y_MAX;
    else if (sh < ACC_YMIN) return Y_MIN;
    else                    return sh[SAMP_W-1:0];
  endfunction

  function automatic logic [1:0] slice(input logic signed [SAMP_W-1:0] yv);
    if (yv < SLICE_LO)       return 2'b00;
    else if (yv < SLICE_MID) return 2'b01;
    else if (yv < SLICE_HI)  return 2'b10;
    else                     return 2'b11;
  endfunction

endpackage

// File: rtl/mf_coeff_rom.sv
// Combinational coefficient lookup (set, tap index) -> b[k].
module mf_coeff_rom
  import mf_pkg::*;
(
  input  logic [2:0]               coeff_sel_i,
  input  logic [3:0]               k_i,
  output logic signed [SAMP_W-1:0] b_o
);

  always_comb begin
    b_o = COEFF_TBL[coeff_sel_i][k_i];
  end

endmodule

// File: rtl/mf_decim_rx.sv
// 31-tap symmetric matched filter, 4:1 decimation, one time-shared MAC.
// Optional 4-level slicer on sym_out when MF_SLICER_EN is defined.
module mf_decim_rx
  import mf_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     samp_ena,
  input  logic [SAMP_W-1:0]        x_in,
  input  logic [1:0]               phase_sel,
  input  logic [2:0]               coeff_sel,
  output logic [SAMP_W-1:0]        y,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun
`ifdef MF_SLICER_EN
  , output logic [1:0]             sym_out
`endif
);

  logic signed [SAMP_W-1:0] line_q [NTAPS];
  logic [1:0]               phase_cnt_q;
  mf_state_e                state_q, state_d;
  logic [3:0]               k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [2:0]               csel_q, csel_d;
  logic signed [SAMP_W-1:0] y_q, y_d;
  logic                     yv_q, yv_d;
  logic                     ovr_q, ovr_d;
`ifdef MF_SLICER_EN
  logic [1:0]               sym_q, sym_d;
`endif

  logic                     trigger;
  logic [4:0]               mirror_idx;
  logic signed [SAMP_W-1:0] x_hi, x_lo, pair_sum, coeff_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [SAMP_W-1:0] y_sat;

  assign trigger = samp_ena && (phase_cnt_q == phase_sel);

  mf_coeff_rom u_rom (
    .coeff_sel_i (csel_q),
    .k_i         (k_q),
    .b_o         (coeff_b)
  );

  // Line shifts on every sample regardless of FSM state.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) line_q[i] <= '0;
      phase_cnt_q <= '0;
    end else if (samp_ena) begin
      line_q[0] <= $signed(x_in) >>> 1;
      for (int unsigned i = 1; i < NTAPS; i++) line_q[i] <= line_q[i-1];
      phase_cnt_q <= phase_cnt_q + 2'd1;
    end
  end

  // Centre tap (k = 15) has no mirror partner.
  always_comb begin
    mirror_idx = 5'(NTAPS - 1) - {1'b0, k_q};
    x_hi       = line_q[k_q];
    x_lo       = (k_q == 4'd15) ? '0 : line_q[mirror_idx];
    pair_sum   = x_hi + x_lo;
    prod       = pair_sum * coeff_b;
    y_sat      = sat_y(acc_q);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    csel_d  = csel_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    ovr_d   = ovr_q;
`ifdef MF_SLICER_EN
    sym_d   = sym_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_MAC;
          k_d     = '0;
          acc_d   = '0;
          csel_d  = coeff_sel;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        k_d   = k_q + 4'd1;
        if (k_q == 4'd15) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        y_d     = y_sat;
        yv_d    = 1'b1;
        state_d = ST_IDLE;
`ifdef MF_SLICER_EN
        sym_d   = slice(y_sat);
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (trigger && (state_q != ST_IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      csel_q  <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef MF_SLICER_EN
      sym_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      csel_q  <= csel_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      ovr_q   <= ovr_d;
`ifdef MF_SLICER_EN
      sym_q   <= sym_d;
`endif
    end
  end

  assign y       = y_q;
  assign y_valid = yv_q;
  assign busy    = (state_q != ST_IDLE);
  assign overrun = ovr_q;
`ifdef MF_SLICER_EN
  assign sym_out = sym_q;
`endif

endmodule

// File: tb/tb_mf_decim_rx.sv
// Directed self-checking bench for mf_decim_rx (slicer checks under MF_SLICER_EN).
module tb_mf_decim_rx;

  logic        sys_clk;
  logic        reset_n;
  logic        samp_ena;
  logic [17:0] x_in;
  logic [1:0]  phase_sel;
  logic [2:0]  coeff_sel;
  logic [17:0] y;
  logic        y_valid;
  logic        busy;
  logic        overrun;
`ifdef MF_SLICER_EN
  logic [1:0]  sym_out;
`endif

  mf_decim_rx dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .samp_ena  (samp_ena),
    .x_in      (x_in),
    .phase_sel (phase_sel),
    .coeff_sel (coeff_sel),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .overrun   (overrun)
`ifdef MF_SLICER_EN
    , .sym_out (sym_out)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int cap_n = 0;
  int last_vcyc = -1;
  logic signed [17:0] cap_y = '0;

  // Impulse of 65536 (stored 32768) reaching positions 3,7,..,23 and 0,4,..,16.
  int exp_ph3 [6] = '{0, 0, -3153, 52429, -3153, 0};
  int exp_ph0 [5] = '{0, 0, 0, 11673, 46287};

  task automatic check(input string tag, input logic signed [39:0] obs,
                       input logic signed [39:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    if (y_valid === 1'b1) begin
      cap_y = $signed(y);
      cap_n++;
      last_vcyc = cyc;
    end
  endtask

  task automatic send(input logic [17:0] xv, input int gap);
    samp_ena = 1'b1;
    x_in     = xv;
    tick();
    samp_ena = 1'b0;
    x_in     = '0;
    repeat (gap - 1) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  int c0;
  int base;

  initial begin
    reset_n = 1'b0; samp_ena = 1'b0; x_in = '0; phase_sel = 2'd0; coeff_sel = 3'd0;
    tick();
    tick();
    check("rst_y", $signed(y), 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    tick();

    // Latency: trigger edge T, y_valid only in the cycle after T+17
    c0 = cyc;
    samp_ena = 1'b1;
    x_in = 18'd0;
    tick();
    samp_ena = 1'b0;
    check("lat_busy_T1", busy, 1);
    repeat (16) tick();
    check("lat_yv_T17", y_valid, 0);
    tick();
    check("lat_yv_T18", y_valid, 1);
    tick();
    check("lat_yv_T19", y_valid, 0);
    check("lat_busy_done", busy, 0);
    check("lat_vcyc", last_vcyc, c0 + 18);

    // Impulse, phase 3, slow samples so the line is static during each MAC
    do_reset();
    phase_sel = 2'd3;
    base = cap_n;
    for (int i = 0; i < 24; i++) begin
      send((i == 0) ? 18'd65536 : 18'd0, 20);
      if (i % 4 == 3) check("imp_ph3", cap_y, exp_ph3[i/4]);
    end
    check("imp_ph3_count", cap_n, base + 6);

    // Impulse, phase 0
    do_reset();
    phase_sel = 2'd0;
    for (int i = 0; i < 20; i++) begin
      send((i == 0) ? 18'd65536 : 18'd0, 20);
      if (i % 4 == 0) check("imp_ph0", cap_y, exp_ph0[i/4]);
    end

    // DC 16384 at the minimum sample spacing
    do_reset();
    for (int i = 0; i < 44; i++) begin
      send(18'd16384, 5);
      if (i == 39) check("dc_mid", cap_y, 55769);
    end
    repeat (25) tick();
    check("dc_end", cap_y, 55769);
    check("dc_no_overrun", overrun, 0);

    // Reset 8 edges into a sequence: aborted, outputs cleared, no y_valid
    base = cap_n;
    send(18'd16384, 1);
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    check("abort_y", $signed(y), 0);
    check("abort_busy", busy, 0);
    check("abort_y_valid", y_valid, 0);
    tick();
    reset_n = 1'b1;
    repeat (25) tick();
    check("abort_no_valid", cap_n, base);

    // Saturation both ways, then a zero coefficient set
    for (int i = 0; i < 40; i++) send(18'd131071, 5);
    repeat (20) tick();
    check("sat_pos", cap_y, 131071);
    for (int i = 0; i < 40; i++) send(18'h20000, 5);
    repeat (20) tick();
    check("sat_neg", cap_y, -131072);
    coeff_sel = 3'd5;
    base = cap_n;
    for (int i = 0; i < 8; i++) send(18'h20000, 5);
    repeat (20) tick();
    check("cset5_zero", cap_y, 0);
    check("cset5_count", cap_n, base + 2);
    coeff_sel = 3'd0;

    // Overrun: samples every 3 cycles
    do_reset();
    base = cap_n;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(18'd1000, 3);
      if (i == 3) check("ovr_before", overrun, 0);
      if (i == 4) check("ovr_rise", overrun, 1);
    end
    check("ovr_sticky", overrun, 1);
    check("ovr_valid_count", cap_n, base + 1);
    check("ovr_valid_cyc", last_vcyc, c0 + 18);

`ifdef MF_SLICER_EN
    begin
      logic [17:0] sx [4];
      logic [1:0]  ss [4];
      sx = '{18'h3A430, 18'h3FFE2, 18'd30, 18'd23504};
      ss = '{2'b00, 2'b01, 2'b10, 2'b11};
      for (int j = 0; j < 4; j++) begin
        do_reset();
        for (int i = 0; i < 36; i++) send(sx[j], 5);
        repeat (20) tick();
        check("slicer", sym_out, ss[j]);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
